fetch_queue: RTL

Instruction prefetch queue. It sits between the instruction ROM and the IF/ID pipeline register, and owns the fetch PC.
- Each cycle it presents the fetch address to the combinational ROM and pushes {opcode, PC+4} into a small FIFO.
- The IF/ID register consumes entries through a valid/ready handshake.
- A redirect (branch/jump resolved downstream) flushes the queue and reloads the fetch PC.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue_fifo.sv | 77 +++++++
 rtl/fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants and types for the instruction prefetch queue.
//             INSTR_W  - native instruction word width
//             PC_INC   - fetch PC increment per fetched word
//             RESET_PC - fetch PC value after reset
//             fetch_entry_t - one queue entry {opcode, next PC}
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int FETCH_ADDR_W = 32;
    localparam int PC_INC       = 4;
    localparam int RESET_PC     = 0;

    // Layout of a queue entry for the native 32/32 configuration; the top
    // packs entries in this same {opcode, next_pc} order for any width.
    typedef struct packed {
        logic [INSTR_W-1:0]      opcode;
        logic [FETCH_ADDR_W-1:0] next_pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_fifo
//  Purpose  : Generic synchronous FIFO with flush, asynchronous reset.
//             Head data is presented combinationally and forced to zero while
//             the FIFO is empty so stale storage never reaches the consumer.
//  Ports    : clk, rst    - clock / asynchronous active-high reset
//             flush       - empty the FIFO (takes priority over push/pop)
//             push, wdata - write one entry (caller guarantees space, or a
//                           simultaneous pop)
//             pop         - retire the head entry (caller guarantees !empty)
//             rdata       - head entry, zero when empty
//             count       - occupancy, full, empty - status
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                // DEPTH is a power of two, so the pointer wraps by overflow.
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction prefetch queue between the instruction ROM and the
//             IF/ID register. Owns the fetch PC, pushes {opcode, PC+4} each
//             cycle there is room, hands entries out over valid/ready, and
//             flushes/reloads on a downstream redirect.
//  Ports    : CLK, Reset           - clock / asynchronous active-high reset
//             romAddress, romData  - combinational ROM interface
//             redirect, redirectAddress - flush and reload the fetch PC
//             entireOpCode_out, newAddress_out, outValid, outReady - head
//             count                - occupancy
//             stallCycles, redirectCount - present only with the
//                                    FETCH_QUEUE_STATS_EN macro defined
//  Config   : `define FETCH_QUEUE_STATS_EN to add the saturating counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   Reset,
    output logic [ADDR_W-1:0]      romAddress,
    input  logic [DATA_W-1:0]      romData,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirectAddress,
    output logic [DATA_W-1:0]      entireOpCode_out,
    output logic [ADDR_W-1:0]      newAddress_out,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]            stallCycles,
    output logic [15:0]            redirectCount
`endif
);

    localparam int c_entry_w = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    w_pc_next;
    logic                 w_pop_req;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [c_entry_w-1:0] w_head;

    assign w_pc_next = r_fetch_pc + ADDR_W'(PC_INC);

    // Redirect wins over both sides: the head is kept (then flushed) even if
    // the consumer is ready, and nothing fetched from the stale PC is queued.
    // A pop in the same cycle frees the slot, so a full queue still pushes.
    assign w_pop_req = outValid & outReady;
    assign w_pop     = w_pop_req & ~redirect;
    assign w_push    = ~redirect & (~w_full | w_pop_req);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_fetch_pc <= ADDR_W'(RESET_PC);
        end else if (redirect) begin
            r_fetch_pc <= redirectAddress;
        end else if (w_push) begin
            r_fetch_pc <= w_pc_next;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .flush (redirect),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({romData, w_pc_next}),
        .rdata (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign romAddress       = r_fetch_pc;
    assign outValid         = ~w_empty;
    assign entireOpCode_out = w_head[c_entry_w-1:ADDR_W];
    assign newAddress_out   = w_head[ADDR_W-1:0];

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_redirect_count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if (outValid && !outReady && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (redirect && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
        end
    end

    assign stallCycles   = r_stall_cycles;
    assign redirectCount = r_redirect_count;
`endif

endmodule
`default_nettype wire
